// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and 2-bit SPI command codes shared by the slave
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT} state_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: latches a read word on load_i and drives it on miso_o one bit per clk; clr_i drops it, done_o flags the final bit
module spi_tx_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  miso_o,
  output logic                  active_o,
  output logic                  done_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0] cnt_q;
  logic active_q, miso_q;
  assign done_o = active_q && cnt_q == '0;
  assign active_o = active_q;
  assign miso_o = miso_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sh_q <= '0;
      cnt_q <= '0;
      active_q <= 1'b0;
      miso_q <= 1'b0;
    end else if (load_i) begin
      sh_q <= LSB_FIRST != 0 ? data_i >> 1 : data_i << 1;
      cnt_q <= CW'(DATA_WIDTH - 1);
      active_q <= 1'b1;
      miso_q <= LSB_FIRST != 0 ? data_i[0] : data_i[DATA_WIDTH-1];
    end else if (active_q) begin
      sh_q <= LSB_FIRST != 0 ? sh_q >> 1 : sh_q << 1;
      cnt_q <= done_o ? '0 : cnt_q - 1'b1;
      active_q <= !done_o;
      miso_q <= !done_o && (LSB_FIRST != 0 ? sh_q[0] : sh_q[DATA_WIDTH-1]);
    end
  end
endmodule

// File: rtl/spi_slave_burst.sv
// spi_slave_burst: SPI slave (SS_n/MOSI in, MISO out) receiving {cmd,payload} frames on rx_valid/rx_data, serialising tx_data read words with optional bursts, abort_err on early SS_n release
module spi_slave_burst
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 0,
  parameter int BURST_EN   = 1,
  localparam int PAYLOAD_W = ADDR_SIZE > DATA_WIDTH ? ADDR_SIZE : DATA_WIDTH,
  localparam int FRAME_W   = PAYLOAD_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  MISO,
  output logic                  rx_valid,
  output logic [FRAME_W-1:0]    rx_data,
  output logic                  abort_err
);
  localparam int CNT_W = $clog2(FRAME_W);
  state_t state_q;
  logic rd_flag_q, rx_valid_q, abort_q;
  logic [CNT_W-1:0] cnt_q;
  logic [FRAME_W-2:0] rsh_q;
  logic [FRAME_W-1:0] rx_data_q;
  logic tx_load, tx_active, tx_done, last_bit;
  assign tx_load = state_q == TX_WAIT && tx_valid && !SS_n;
  assign last_bit = cnt_q == CNT_W'(FRAME_W - 2);
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
  assign abort_err = abort_q;
  spi_tx_shifter #(.DATA_WIDTH(DATA_WIDTH), .LSB_FIRST(LSB_FIRST)) u_tx (
    .clk(clk), .rst(rst), .clr_i(SS_n), .load_i(tx_load), .data_i(tx_data),
    .miso_o(MISO), .active_o(tx_active), .done_o(tx_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_flag_q <= 1'b0;
      cnt_q <= '0;
      rsh_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
      abort_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: state_q <= SS_n ? IDLE : CHK_CMD;
        CHK_CMD: begin
          rsh_q <= {rsh_q[FRAME_W-3:0], MOSI};
          cnt_q <= '0;
          abort_q <= SS_n;
          state_q <= SS_n ? IDLE : MOSI == CMD_WR_ADDR[1] ? WRITE : rd_flag_q ? READ_DATA : READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          rsh_q <= {rsh_q[FRAME_W-3:0], MOSI};
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            // SS_n rising together with the last bit still completes the frame
            rx_valid_q <= 1'b1;
            rx_data_q <= {rsh_q, MOSI};
            rd_flag_q <= rd_flag_q || state_q == READ_ADD;
            state_q <= state_q == READ_DATA && !SS_n ? TX_WAIT : IDLE;
          end else if (SS_n) begin
            abort_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        TX_WAIT: begin
          rd_flag_q <= rd_flag_q && !SS_n;
          state_q <= SS_n ? IDLE : tx_valid ? TX_SHIFT : TX_WAIT;
        end
        TX_SHIFT: begin
          if (tx_done && !SS_n && BURST_EN != 0) begin
            rx_valid_q <= 1'b1;
            rx_data_q <= {CMD_RD_DATA, {PAYLOAD_W{1'b0}}};
            state_q <= TX_WAIT;
          end else if (tx_done || SS_n) begin
            // non-burst completion parks here until SS_n rises; an early rise aborts
            rd_flag_q <= 1'b0;
            abort_q <= SS_n && tx_active && !tx_done;
            state_q <= SS_n ? IDLE : TX_SHIFT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
